// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed byte stream and writes little-endian 32-bit words into
// instruction memory, holding the CPU for the duration of the load.
module imem_boot_loader #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        mem_write_o,
    output logic        mem_read_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        cpu_hold_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [15:0] words_loaded_o
);
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] Limit = 32'(DEPTH - BASE_ADDR);

    typedef enum logic [2:0] {
        StIdle, StHdr0, StHdr1, StBytes, StWrite, StDone, StError
    } state_e;

    state_e        state_q;
    logic [15:0]   n_q;
    logic [15:0]   count_q;
    logic [1:0]    byte_idx_q;
    logic [23:0]   word_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;

    logic        xfer;
    logic [15:0] n_full;

    assign xfer   = byte_valid_i && byte_ready_o;
    assign n_full = {byte_data_i, n_q[7:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            n_q        <= '0;
            count_q    <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            case (state_q)
                StIdle, StDone, StError: begin
                    if (start_i) begin
                        state_q    <= StHdr0;
                        count_q    <= '0;
                        byte_idx_q <= '0;
                    end
                end
                StHdr0: begin
                    if (xfer) begin
                        n_q[7:0] <= byte_data_i;
                        state_q  <= StHdr1;
                    end
                end
                StHdr1: begin
                    if (xfer) begin
                        n_q[15:8]  <= byte_data_i;
                        byte_idx_q <= '0;
                        if (n_full == 16'd0) begin
                            state_q <= StDone;
                        end else if ({16'd0, n_full} > Limit) begin
                            state_q <= StError;
                        end else begin
                            state_q <= StBytes;
                        end
                    end
                end
                StBytes: begin
                    if (xfer) begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                        case (byte_idx_q)
                            2'd0: word_q[7:0]   <= byte_data_i;
                            2'd1: word_q[15:8]  <= byte_data_i;
                            2'd2: word_q[23:16] <= byte_data_i;
                            default: begin
                                // Last byte goes straight into the write register.
                                wdata_q <= {byte_data_i, word_q};
                                addr_q  <= AW'(BASE_ADDR) + AW'(count_q);
                                state_q <= StWrite;
                            end
                        endcase
                    end
                end
                StWrite: begin
                    count_q <= count_q + 16'd1;
                    state_q <= (count_q + 16'd1 == n_q) ? StDone : StBytes;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o         = (state_q == StHdr0) || (state_q == StHdr1) ||
                            (state_q == StBytes) || (state_q == StWrite);
    assign byte_ready_o   = (state_q == StHdr0) || (state_q == StHdr1) || (state_q == StBytes);
    assign mem_write_o    = (state_q == StWrite);
    assign done_o         = (state_q == StDone);
    assign error_o        = (state_q == StError);
    assign cpu_hold_o     = busy_o;
    assign mem_read_o     = 1'b0;
    assign mem_addr_o     = 32'(addr_q);
    assign mem_wdata_o    = wdata_q;
    assign words_loaded_o = count_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed load scenarios with random data and gaps,
// checked against a stream/word reference model and a behavioural instruction memory.
module tb_imem_boot_loader;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       valid;
    logic [7:0] data;
    logic       sel_hi;

    always #5 clk = ~clk;

    logic        m_ready, m_write, m_read, m_hold, m_busy, m_done, m_error;
    logic [31:0] m_addr, m_wdata;
    logic [15:0] m_wl;
    logic        h_ready, h_write, h_read, h_hold, h_busy, h_done, h_error;
    logic [31:0] h_addr, h_wdata;
    logic [15:0] h_wl;

    imem_boot_loader dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start & ~sel_hi),
        .byte_valid_i   (valid & ~sel_hi),
        .byte_data_i    (data),
        .byte_ready_o   (m_ready),
        .mem_write_o    (m_write),
        .mem_read_o     (m_read),
        .mem_addr_o     (m_addr),
        .mem_wdata_o    (m_wdata),
        .cpu_hold_o     (m_hold),
        .busy_o         (m_busy),
        .done_o         (m_done),
        .error_o        (m_error),
        .words_loaded_o (m_wl)
    );

    imem_boot_loader #(.DEPTH(1024), .BASE_ADDR(1020)) dut_hi (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start & sel_hi),
        .byte_valid_i   (valid & sel_hi),
        .byte_data_i    (data),
        .byte_ready_o   (h_ready),
        .mem_write_o    (h_write),
        .mem_read_o     (h_read),
        .mem_addr_o     (h_addr),
        .mem_wdata_o    (h_wdata),
        .cpu_hold_o     (h_hold),
        .busy_o         (h_busy),
        .done_o         (h_done),
        .error_o        (h_error),
        .words_loaded_o (h_wl)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] imem [0:1023];
    logic [31:0] m_addr_q [$];
    logic [31:0] m_data_q [$];
    bit          m_ok_q [$];
    logic [31:0] h_addr_q [$];
    int          m_xfers = 0;
    bit          m_prev = 1'b0;
    int          xfer_base = 0;

    logic [31:0] words [$];
    logic [7:0]  stream [$];

    // Write monitor: a write is legal only one cycle after the 4th byte of a word transferred.
    initial begin
        forever begin
            @(negedge clk);
            if (m_write) begin
                m_addr_q.push_back(m_addr);
                m_data_q.push_back(m_wdata);
                m_ok_q.push_back(!m_ready && m_prev && (m_xfers - xfer_base) >= 6 &&
                                 ((m_xfers - xfer_base - 2) % 4 == 0));
                imem[m_addr[9:0]] = m_wdata;
            end
            if (h_write) h_addr_q.push_back(h_addr);
            m_prev = valid && !sel_hi && m_ready;
            if (m_prev) m_xfers++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference stream: 16-bit count little-endian, then each word little-endian.
    task automatic make_stream();
        logic [15:0] n16;
        logic [31:0] w;
        n16 = 16'(words.size());
        stream.delete();
        stream.push_back(n16[7:0]);
        stream.push_back(n16[15:8]);
        for (int k = 0; k < words.size(); k++) begin
            w = words[k];
            stream.push_back(w[7:0]);
            stream.push_back(w[15:8]);
            stream.push_back(w[23:16]);
            stream.push_back(w[31:24]);
        end
    endtask

    task automatic clear_log();
        m_addr_q.delete();
        m_data_q.delete();
        m_ok_q.delete();
        h_addr_q.delete();
        xfer_base = m_xfers;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int max_gap, input int start_at, input int nbytes);
        int  i = 0;
        int  gap = 0;
        int  budget = 0;
        bit  rdy;
        while (i < nbytes && budget < 20000) begin
            start = (i == start_at);
            if (gap > 0) begin
                valid = 1'b0;
                data  = 8'($urandom);
                gap--;
            end else begin
                valid = 1'b1;
                data  = stream[i];
            end
            rdy = sel_hi ? h_ready : m_ready;
            if (valid && rdy) begin
                i++;
                gap = $urandom_range(max_gap, 0);
            end
            tick();
            budget++;
        end
        valid = 1'b0;
        start = 1'b0;
        if (i < nbytes) begin
            checks++;
            failures++;
            $display("FAIL send_timeout sent=%0d required=%0d", i, nbytes);
        end
    endtask

    task automatic wait_end();
        int b = 0;
        while (!(sel_hi ? (h_done | h_error) : (m_done | m_error)) && b < 50) begin
            tick();
            b++;
        end
        if (b >= 50) begin
            checks++;
            failures++;
            $display("FAIL end_timeout observed=no done/error required=done or error");
        end
    endtask

    task automatic run_main(input int max_gap, input int start_at);
        clear_log();
        make_stream();
        pulse_start();
        chk("busy_after_start", 32'(m_busy), 32'd1);
        chk("done_cleared", 32'(m_done), 32'd0);
        chk("error_cleared", 32'(m_error), 32'd0);
        send(max_gap, start_at, stream.size());
        wait_end();
        chk("done", 32'(m_done), 32'd1);
        chk("error", 32'(m_error), 32'd0);
        chk("cpu_hold_end", 32'(m_hold), 32'd0);
        chk("words_loaded", 32'(m_wl), words.size());
        chk("num_writes", m_addr_q.size(), words.size());
        for (int k = 0; k < words.size() && k < m_addr_q.size(); k++) begin
            chk($sformatf("addr[%0d]", k), m_addr_q[k], k);
            chk($sformatf("wdata[%0d]", k), m_data_q[k], words[k]);
            chk($sformatf("write_timing[%0d]", k), 32'(m_ok_q[k]), 32'd1);
            chk($sformatf("imem[%0d]", k), imem[k], words[k]);
        end
    endtask

    task automatic rand_words(input int n);
        words.delete();
        for (int k = 0; k < n; k++) words.push_back($urandom);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        valid  = 1'b0;
        data   = 8'h00;
        sel_hi = 1'b0;

        // Reset with random inputs.
        repeat (3) begin
            start = 1'($urandom);
            valid = 1'($urandom);
            data  = 8'($urandom);
            tick();
        end
        chk("rst_byte_ready", 32'(m_ready), 32'd0);
        chk("rst_mem_write", 32'(m_write), 32'd0);
        chk("rst_mem_read", 32'(m_read), 32'd0);
        chk("rst_mem_addr", m_addr, 32'd0);
        chk("rst_mem_wdata", m_wdata, 32'd0);
        chk("rst_cpu_hold", 32'(m_hold), 32'd0);
        chk("rst_busy", 32'(m_busy), 32'd0);
        chk("rst_done", 32'(m_done), 32'd0);
        chk("rst_error", 32'(m_error), 32'd0);
        chk("rst_words_loaded", 32'(m_wl), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        tick();
        chk("idle_busy", 32'(m_busy), 32'd0);
        chk("idle_ready", 32'(m_ready), 32'd0);

        // Two-word load, no gaps, then with random gaps, then random words.
        words = '{32'h00A11002, 32'h00A51801};
        run_main(0, -1);
        chk("bytes_check_0", 32'(stream[2]), 32'h02);
        run_main(3, -1);
        rand_words(3);
        run_main(3, -1);

        // Zero-length load.
        words.delete();
        run_main(0, -1);

        // Oversize header (N = 1025), then a clean restart.
        clear_log();
        stream = '{8'h01, 8'h04};
        pulse_start();
        send(0, -1, 2);
        wait_end();
        chk("oversize_error", 32'(m_error), 32'd1);
        chk("oversize_done", 32'(m_done), 32'd0);
        chk("oversize_writes", m_addr_q.size(), 32'd0);
        chk("oversize_hold", 32'(m_hold), 32'd0);
        rand_words(2);
        run_main(1, -1);

        // Reset after one word and two bytes of a three-word load.
        rand_words(3);
        make_stream();
        clear_log();
        pulse_start();
        send(0, -1, 8);
        chk("partial_busy", 32'(m_busy), 32'd1);
        reset = 1'b1;
        tick();
        chk("midrst_busy", 32'(m_busy), 32'd0);
        chk("midrst_write", 32'(m_write), 32'd0);
        chk("midrst_wl", 32'(m_wl), 32'd0);
        chk("midrst_done", 32'(m_done), 32'd0);
        chk("midrst_writes", m_addr_q.size(), 32'd1);
        chk("midrst_imem0", imem[0], words[0]);
        reset = 1'b0;
        tick();
        run_main(2, -1);

        // start pulsed while busy is ignored.
        rand_words(2);
        run_main(0, 5);
        run_main(2, 1);

        // High base: N=5 overflows, N=4 fills the last four locations.
        sel_hi = 1'b1;
        clear_log();
        stream = '{8'h05, 8'h00};
        pulse_start();
        send(0, -1, 2);
        wait_end();
        chk("hi_err", 32'(h_error), 32'd1);
        chk("hi_err_done", 32'(h_done), 32'd0);
        chk("hi_err_writes", h_addr_q.size(), 32'd0);
        rand_words(4);
        make_stream();
        clear_log();
        pulse_start();
        send(1, -1, stream.size());
        wait_end();
        chk("hi_fit_done", 32'(h_done), 32'd1);
        chk("hi_fit_error", 32'(h_error), 32'd0);
        chk("hi_fit_wl", 32'(h_wl), 32'd4);
        chk("hi_fit_writes", h_addr_q.size(), 32'd4);
        if (h_addr_q.size() == 4) begin
            chk("hi_first_addr", h_addr_q[0], 32'd1020);
            chk("hi_last_addr", h_addr_q[3], 32'd1023);
        end
        chk("hi_last_wdata", h_wdata, words[3]);
        chk("main_idle_untouched", m_addr_q.size(), 32'd0);
        sel_hi = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
